icetap_capture_seq: RTL and testbench
=====================================

Name: icetap_capture_seq

Overview:
- Next-generation icetap capture engine in the src_clk domain.
- Records NR_SIGNALS probe signals into a RECORD_DEPTH ring buffer under a per-signal store condition.
- A multi-stage trigger sequencer with per-stage occurrence counts drives the trigger, and the post-trigger depth is programmable.
- Sits behind icetap_scan, replacing icetap_bram, and adds the stage sequencer, post-trigger count, abort and a valid-sample count.

Parameters:
- NR_SIGNALS, 4, number of probed signals.
- RECORD_DEPTH, 16, ring buffer entries; power of 2, at least 2. RAM_ADDR_BITS = clog2(RECORD_DEPTH).
- NR_STAGES, 2, trigger sequencer stages, 1 to 4.
- COUNT_BITS, 8, width of each stage occurrence counter.

Ports:
- src_clk  in  1  capture clock.
- src_reset  in  1  asynchronous, active-high reset.
- signals_in  in  NR_SIGNALS  probed signals.
- store_mask_vec  in  NR_SIGNALS*3  store condition, 3-bit code per signal.
- store_always  in  1  store every cycle; store_mask_vec is ignored.
- trig_mask_vec  in  NR_STAGES*NR_SIGNALS*3  per-stage trigger condition; stage s occupies slice s.
- trig_count_vec  in  NR_STAGES*COUNT_BITS  per-stage required hits; a value of 0 is treated as 1.
- post_count  in  RAM_ADDR_BITS+1  samples to store from the trigger sample onward, inclusive; 0 is treated as 1, values above RECORD_DEPTH are clamped.
- start  in  1  single-cycle pulse: arm a capture.
- abort  in  1  single-cycle pulse: return to IDLE.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- cur_stage  out  2  active trigger stage.
- start_addr  out  RAM_ADDR_BITS  oldest valid sample address.
- trigger_addr  out  RAM_ADDR_BITS  address of the trigger sample.
- stop_addr  out  RAM_ADDR_BITS  address of the last written sample.
- valid_count  out  RAM_ADDR_BITS+1  number of valid samples, 0 to RECORD_DEPTH.
- read_req_first  in  1  load the read pointer with start_addr.
- read_req_next  in  1  advance the read pointer.
- read_data  out  NR_SIGNALS  read sample, registered.

Behaviour:
- Reset: all outputs, pointers and counters are 0; state is IDLE; the previous-sample register is 0.
- Condition codes (per signal, 3 bits):
  - 000 don't-care; 001 high; 010 low; 011 rising; 100 falling; 101 any edge.
  - 110 and 111 are don't-care.
- Edge detection: edges compare signals_in against prev. The prev register updates every cycle in every state.
- Condition evaluation: a condition is the AND over all signals. An all-don't-care condition is true.
- Config capture:
  - All mask, count and post_count inputs are latched on the start cycle.
  - Later changes to these inputs have no effect until the next start.
- Start:
  - start in any state clears wr_ptr, valid_count, stage, hit counter and post counter, and moves to ARMED.
  - No sample is written in the start cycle.
- Abort:
  - abort moves to IDLE and clears valid_count; addresses keep their values.
  - If start and abort arrive in the same cycle, abort wins.
- Write rule:
  - Writes occur only in ARMED or POST, when the store condition is true or on the trigger cycle.
  - Data is written at wr_ptr, then wr_ptr increments with wrap.
  - stop_addr is set to the written address.
  - valid_count increments, saturating at RECORD_DEPTH.
- ARMED state:
  - Each cycle where the current stage condition holds increments hit_cnt. The hits need not be consecutive.
  - When hit_cnt+1 reaches the stage count (a value of 0 is treated as 1), the stage completes: stage increments and hit_cnt clears.
  - Completing the final stage is the trigger cycle:
    - the sample is force-written;
    - trigger_addr is set to wr_ptr;
    - the post counter is set to 1;
    - the state moves to POST, or directly to DONE if post_count is 1.
- POST state:
  - Each write increments the post counter.
  - When the counter reaches post_count, the state moves to DONE after that write.
  - Trigger conditions are ignored in POST.
- DONE state: no writes occur; the state holds until the next start.
- start_addr:
  - Equals 0 while valid_count < RECORD_DEPTH.
  - Otherwise equals wr_ptr, the oldest entry.
  - Updates combinationally from registers.
- Pre-trigger overwrite: samples written in ARMED that are older than RECORD_DEPTH - post_count may be overwritten. This is intended ring behaviour.
- Read port:
  - read_data is valid on the cycle after the request.
  - read_req_first takes priority over read_req_next.
  - The read pointer wraps at RECORD_DEPTH.
  - Reads are legal in any state; the read port is independent of the write port.
- Simultaneous write and read to the same address returns old data.

Test Plan:
- Basic trigger:
  - Setup: NR_SIGNALS=4, DEPTH=16, store_always, 1 stage with sig0 rising and count 1, post_count=4.
  - Stimulus: rise sig0 on cycle 10 after start.
  - Required: state reaches DONE 3 cycles after the trigger cycle; valid_count=13; trigger_addr=9; stop_addr=12; start_addr=0.
- Wrap:
  - Setup: same config, trigger on cycle 40.
  - Required: valid_count=16; start_addr=stop_addr+1 mod 16; reading 16 samples from read_req_first returns chronological data ending at the trigger+3 sample.
- Sequencer:
  - Setup: stage0 = sig1 high with count 3 (non-consecutive), stage1 = sig2 falling.
  - Stimulus: sig2 falls before the third sig1 hit, then again after it.
  - Required: no trigger on the early fall; cur_stage=1 after the third hit; trigger occurs on the second fall.
- Store mask:
  - Setup: store sig3 high only.
  - Stimulus: sig3 high on alternate cycles; trigger on a cycle where sig3 is low.
  - Required: the trigger sample is stored anyway; valid_count counts only stored cycles plus the trigger sample.
- Abort/restart:
  - Stimulus: abort in POST. Then apply start and abort in the same cycle.
  - Required: state=IDLE and valid_count=0 in both cases. A later start rearms ARMED with wr_ptr=0.
- Async reset mid-capture:
  - Stimulus: assert src_reset in POST, off the clock edge.
  - Required: all outputs read 0 immediately; no writes occur until a new start after reset release.

Source files
------------

// File: rtl/icetap_capture_seq_if.sv
// icetap_capture_seq_if
//   Bundles the probe, configuration, control, status and read-port signals
//   of the icetap capture sequencer. The clock and reset stay plain ports on
//   the design.
//   master : drives probes, config, start/abort and read requests
//   slave  : the capture engine; drives status and read_data
interface icetap_capture_seq_if #(
    parameter int NR_SIGNALS   = 4,
    parameter int RECORD_DEPTH = 16,
    parameter int NR_STAGES    = 2,
    parameter int COUNT_BITS   = 8
);
    localparam int RAM_ADDR_BITS = $clog2(RECORD_DEPTH);

    // probes and configuration
    logic [NR_SIGNALS-1:0]              signals_in;
    logic [NR_SIGNALS*3-1:0]            store_mask_vec;
    logic                               store_always;
    logic [NR_STAGES*NR_SIGNALS*3-1:0]  trig_mask_vec;
    logic [NR_STAGES*COUNT_BITS-1:0]    trig_count_vec;
    logic [RAM_ADDR_BITS:0]             post_count;
    // control
    logic                               start;
    logic                               abort;
    // status
    logic [1:0]                         state;
    logic [1:0]                         cur_stage;
    logic [RAM_ADDR_BITS-1:0]           start_addr;
    logic [RAM_ADDR_BITS-1:0]           trigger_addr;
    logic [RAM_ADDR_BITS-1:0]           stop_addr;
    logic [RAM_ADDR_BITS:0]             valid_count;
    // read port
    logic                               read_req_first;
    logic                               read_req_next;
    logic [NR_SIGNALS-1:0]              read_data;

    modport master (
        output signals_in, store_mask_vec, store_always, trig_mask_vec,
               trig_count_vec, post_count, start, abort,
               read_req_first, read_req_next,
        input  state, cur_stage, start_addr, trigger_addr, stop_addr,
               valid_count, read_data
    );

    modport slave (
        input  signals_in, store_mask_vec, store_always, trig_mask_vec,
               trig_count_vec, post_count, start, abort,
               read_req_first, read_req_next,
        output state, cur_stage, start_addr, trigger_addr, stop_addr,
               valid_count, read_data
    );
endinterface

// File: rtl/icetap_capture_seq.sv
// icetap_capture_seq
//   Capture engine: records probe signals into a ring buffer under a store
//   condition, with a multi-stage trigger sequencer (per-stage hit counts)
//   and a programmable post-trigger depth.
//   Ports:
//     src_clk   : capture clock
//     src_reset : asynchronous, active-high reset
//     bus       : icetap_capture_seq_if.slave (probes, config, start/abort,
//                 status, read port)

// Per-signal condition evaluation; the condition is the AND of all lanes.
module icetap_cond_eval #(
    parameter int NR_SIGNALS = 4
) (
    input  logic [NR_SIGNALS*3-1:0] mask,
    input  logic [NR_SIGNALS-1:0]   cur,
    input  logic [NR_SIGNALS-1:0]   prev,
    output logic                    hit
);
    function automatic logic code_ok(input logic [2:0] code, input logic c, input logic p);
        case (code)
            3'b001:  return c;
            3'b010:  return !c;
            3'b011:  return c & !p;
            3'b100:  return !c & p;
            3'b101:  return c ^ p;
            default: return 1'b1;   // 000, 110, 111: don't care
        endcase
    endfunction

    logic [NR_SIGNALS-1:0] lane_ok;

    for (genvar i = 0; i < NR_SIGNALS; i++) begin : g_lane
        assign lane_ok[i] = code_ok(mask[i*3 +: 3], cur[i], prev[i]);
    end

    assign hit = &lane_ok;
endmodule

module icetap_capture_seq #(
    parameter int NR_SIGNALS   = 4,
    parameter int RECORD_DEPTH = 16,
    parameter int NR_STAGES    = 2,
    parameter int COUNT_BITS   = 8
) (
    input  logic                 src_clk,
    input  logic                 src_reset,
    icetap_capture_seq_if.slave  bus
);
    localparam int AW = $clog2(RECORD_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(RECORD_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    // Configuration snapshot taken on start; counts already normalised
    // (0 -> 1) and post count clamped to 1..RECORD_DEPTH.
    typedef struct packed {
        logic                                     store_always;
        logic [NR_SIGNALS*3-1:0]                  store_mask;
        logic [NR_STAGES-1:0][NR_SIGNALS*3-1:0]   trig_mask;
        logic [NR_STAGES-1:0][COUNT_BITS-1:0]     trig_cnt;
        logic [CW-1:0]                            post_cnt;
    } cfg_t;

    cfg_t                  cfg_d, cfg_q;
    state_t                state_q;
    logic [1:0]            stage_q;
    logic [COUNT_BITS-1:0] hit_q;
    logic [CW-1:0]         post_q;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         vcount;
    logic [AW-1:0]         trig_addr;
    logic [AW-1:0]         stop_addr;
    logic [AW-1:0]         rd_ptr;
    logic [NR_SIGNALS-1:0] rd_data;
    logic [NR_SIGNALS-1:0] prev_q;
    logic [NR_SIGNALS-1:0] mem [RECORD_DEPTH];

    logic                  store_hit;
    logic [NR_STAGES-1:0]  trig_hit;
    logic                  stage_hit;
    logic [COUNT_BITS-1:0] stage_cnt;
    logic                  last_stage;
    logic [COUNT_BITS-1:0] hit_nx;
    logic                  stage_done;
    logic                  trigger;
    logic                  wr_en;
    logic [CW-1:0]         post_nx;
    logic [AW-1:0]         start_addr;

    always_comb begin
        cfg_d              = '0;
        cfg_d.store_always = bus.store_always;
        cfg_d.store_mask   = bus.store_mask_vec;
        cfg_d.trig_mask    = bus.trig_mask_vec;
        for (int s = 0; s < NR_STAGES; s++) begin
            cfg_d.trig_cnt[s] = bus.trig_count_vec[s*COUNT_BITS +: COUNT_BITS];
            if (cfg_d.trig_cnt[s] == '0)
                cfg_d.trig_cnt[s] = COUNT_BITS'(1);
        end
        if (bus.post_count == '0)
            cfg_d.post_cnt = CW'(1);
        else if (bus.post_count > DEPTH_V)
            cfg_d.post_cnt = DEPTH_V;
        else
            cfg_d.post_cnt = bus.post_count;
    end

    icetap_cond_eval #(.NR_SIGNALS(NR_SIGNALS)) u_store (
        .mask(cfg_q.store_mask), .cur(bus.signals_in), .prev(prev_q), .hit(store_hit)
    );

    for (genvar s = 0; s < NR_STAGES; s++) begin : g_stage
        icetap_cond_eval #(.NR_SIGNALS(NR_SIGNALS)) u_trig (
            .mask(cfg_q.trig_mask[s]), .cur(bus.signals_in), .prev(prev_q), .hit(trig_hit[s])
        );
    end

    // Select the active stage's condition and count.
    always_comb begin
        stage_hit  = 1'b0;
        stage_cnt  = '0;
        last_stage = 1'b0;
        for (int s = 0; s < NR_STAGES; s++) begin
            if (stage_q == 2'(s)) begin
                stage_hit  = trig_hit[s];
                stage_cnt  = cfg_q.trig_cnt[s];
                last_stage = (s == NR_STAGES - 1);
            end
        end
    end

    assign hit_nx     = hit_q + COUNT_BITS'(1);
    assign stage_done = stage_hit && (hit_nx == stage_cnt);
    assign trigger    = (state_q == ARMED) && stage_done && last_stage;
    assign post_nx    = post_q + CW'(1);
    // start and abort suppress any write in their cycle.
    assign wr_en      = !bus.abort && !bus.start &&
                        (((state_q == ARMED) && (cfg_q.store_always || store_hit || trigger)) ||
                         ((state_q == POST)  && (cfg_q.store_always || store_hit)));
    assign start_addr = (vcount == DEPTH_V) ? wr_ptr : '0;

    always_ff @(posedge src_clk or posedge src_reset) begin
        if (src_reset) begin
            cfg_q     <= '0;
            state_q   <= IDLE;
            stage_q   <= '0;
            hit_q     <= '0;
            post_q    <= '0;
            wr_ptr    <= '0;
            vcount    <= '0;
            trig_addr <= '0;
            stop_addr <= '0;
            prev_q    <= '0;
        end else begin
            prev_q <= bus.signals_in;
            if (bus.abort) begin
                state_q <= IDLE;
                vcount  <= '0;
            end else if (bus.start) begin
                cfg_q   <= cfg_d;
                state_q <= ARMED;
                wr_ptr  <= '0;
                vcount  <= '0;
                stage_q <= '0;
                hit_q   <= '0;
                post_q  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr    <= wr_ptr + AW'(1);
                    stop_addr <= wr_ptr;
                    if (vcount != DEPTH_V)
                        vcount <= vcount + CW'(1);
                end
                case (state_q)
                    ARMED: begin
                        if (stage_done) begin
                            if (last_stage) begin
                                trig_addr <= wr_ptr;
                                post_q    <= CW'(1);
                                state_q   <= (cfg_q.post_cnt == CW'(1)) ? DONE : POST;
                            end else begin
                                stage_q <= stage_q + 2'd1;
                                hit_q   <= '0;
                            end
                        end else if (stage_hit) begin
                            hit_q <= hit_nx;
                        end
                    end
                    POST: begin
                        if (wr_en) begin
                            post_q <= post_nx;
                            if (post_nx == cfg_q.post_cnt)
                                state_q <= DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample RAM: no reset, read-before-write on address collision.
    always_ff @(posedge src_clk) begin
        if (wr_en)
            mem[wr_ptr] <= bus.signals_in;
    end

    always_ff @(posedge src_clk or posedge src_reset) begin
        if (src_reset) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (bus.read_req_first) begin
            rd_data <= mem[start_addr];
            rd_ptr  <= start_addr + AW'(1);
        end else if (bus.read_req_next) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
        end
    end

    assign bus.state        = state_q;
    assign bus.cur_stage    = stage_q;
    assign bus.start_addr   = start_addr;
    assign bus.trigger_addr = trig_addr;
    assign bus.stop_addr    = stop_addr;
    assign bus.valid_count  = vcount;
    assign bus.read_data    = rd_data;
endmodule

// File: tb/tb_icetap_capture_seq.sv
module tb_icetap_capture_seq;
    localparam int F_STATE = 0, F_STAGE = 1, F_START = 2, F_TRIG = 3,
                   F_STOP = 4, F_VCNT = 5, F_RDATA = 6;

    logic src_clk = 1'b0;
    logic src_reset = 1'b1;
    always #5 src_clk = ~src_clk;

    icetap_capture_seq_if #(.NR_SIGNALS(4), .RECORD_DEPTH(16), .NR_STAGES(2), .COUNT_BITS(8)) bus();

    icetap_capture_seq #(.NR_SIGNALS(4), .RECORD_DEPTH(16), .NR_STAGES(2), .COUNT_BITS(8)) dut (
        .src_clk(src_clk), .src_reset(src_reset), .bus(bus)
    );

    typedef struct { string name; int field; int val; } exp_t;
    exp_t stat_q[$];
    int   rd_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rd_vld;
    logic flush = 1'b0;

    function automatic int field_val(int f);
        case (f)
            F_STATE: return int'(bus.state);
            F_STAGE: return int'(bus.cur_stage);
            F_START: return int'(bus.start_addr);
            F_TRIG:  return int'(bus.trigger_addr);
            F_STOP:  return int'(bus.stop_addr);
            F_VCNT:  return int'(bus.valid_count);
            default: return int'(bus.read_data);
        endcase
    endfunction

    always @(posedge src_clk or posedge src_reset)
        if (src_reset) rd_vld <= 1'b0;
        else           rd_vld <= bus.read_req_first | bus.read_req_next;

    // Monitor: drains status expectations and checks read data when it is presented.
    always @(negedge src_clk) begin
        exp_t e;
        int   got;
        int   want;
        while (stat_q.size() > 0) begin
            e   = stat_q.pop_front();
            got = field_val(e.field);
            n_cmp++;
            if (got != e.val) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d", e.name, got, e.val);
            end
        end
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL read_unexpected: got %0h expected no read", bus.read_data);
            end else begin
                want = rd_q.pop_front();
                if (int'(bus.read_data) != want) begin
                    n_bad++;
                    $display("FAIL read_data: got %0h expected %0h", bus.read_data, want);
                end
            end
        end
        if (flush && rd_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_missing: got 0 reads expected %0d more", rd_q.size());
            rd_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic chk(input string n, input int f, input int v);
        stat_q.push_back('{n, f, v});
    endtask

    task automatic cyc(input logic [3:0] s);
        bus.signals_in = s;
        tick();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic cfg_basic(input int post);
        bus.store_always   = 1'b1;
        bus.store_mask_vec = '0;
        bus.trig_mask_vec  = {12'h003, 12'h000};   // stage0 don't care, stage1 sig0 rising
        bus.trig_count_vec = {8'd1, 8'd0};         // stage0 count 0 acts as 1
        bus.post_count     = 5'(post);
    endtask

    // Sample pattern: sig0 high from cycle trig on, sig[3:1] = low bits of cycle.
    function automatic logic [3:0] sv(input int c, input int trig);
        logic [31:0] cv;
        cv = 32'(c);
        return {cv[2:0], (c >= trig)};
    endfunction

    task automatic read_block(input int first_c, input int n, input int trig);
        bus.read_req_first = 1'b1;
        rd_q.push_back(int'(sv(first_c, trig)));
        tick();
        bus.read_req_first = 1'b0;
        for (int i = 1; i < n; i++) begin
            bus.read_req_next = 1'b1;
            rd_q.push_back(int'(sv(first_c + i, trig)));
            tick();
        end
        bus.read_req_next = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.signals_in = '0; bus.store_mask_vec = '0; bus.store_always = 1'b0;
        bus.trig_mask_vec = '0; bus.trig_count_vec = '0; bus.post_count = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.read_req_first = 1'b0; bus.read_req_next = 1'b0;

        // reset state
        tick();
        chk("rst_state", F_STATE, 0); chk("rst_stage", F_STAGE, 0);
        chk("rst_start", F_START, 0); chk("rst_trig", F_TRIG, 0);
        chk("rst_stop", F_STOP, 0);   chk("rst_vcnt", F_VCNT, 0);
        chk("rst_rdata", F_RDATA, 0);
        tick();
        src_reset = 1'b0;
        tick();

        // basic trigger: rising sig0 on cycle 10, post 4
        cfg_basic(4);
        do_start();
        chk("basic_armed", F_STATE, 1); chk("basic_vc0", F_VCNT, 0);
        for (int c = 1; c <= 13; c++) begin
            cyc(sv(c, 10));
            if (c == 1)  chk("basic_stage1", F_STAGE, 1);
            if (c == 9)  chk("basic_pretrig", F_STATE, 1);
            if (c == 10) begin chk("basic_post", F_STATE, 2); chk("basic_trig_early", F_TRIG, 9); end
            if (c == 12) chk("basic_post_still", F_STATE, 2);
        end
        chk("basic_done", F_STATE, 3); chk("basic_vcnt", F_VCNT, 13);
        chk("basic_trig", F_TRIG, 9);  chk("basic_stop", F_STOP, 12);
        chk("basic_start", F_START, 0);
        cyc(4'hF); cyc(4'h0);
        chk("done_hold_vcnt", F_VCNT, 13); chk("done_hold_stop", F_STOP, 12);
        read_block(1, 2, 10);

        // wrap: trigger on cycle 40
        do_start();
        for (int c = 1; c <= 43; c++) cyc(sv(c, 40));
        chk("wrap_done", F_STATE, 3); chk("wrap_vcnt", F_VCNT, 16);
        chk("wrap_trig", F_TRIG, 7);  chk("wrap_stop", F_STOP, 10);
        chk("wrap_start", F_START, 11);
        cyc(4'h0);
        read_block(28, 16, 40);

        // sequencer: stage0 sig1 high x3, stage1 sig2 falling
        bus.trig_mask_vec  = {12'h100, 12'h008};
        bus.trig_count_vec = {8'd1, 8'd3};
        bus.post_count     = 5'd2;
        bus.signals_in     = 4'h0;
        do_start();
        cyc(4'b0100); cyc(4'b0110); cyc(4'b0100); cyc(4'b0110);
        cyc(4'b0000);
        chk("seq_early_state", F_STATE, 1); chk("seq_early_stage", F_STAGE, 0);
        cyc(4'b0010);
        chk("seq_stage1", F_STAGE, 1); chk("seq_stage1_state", F_STATE, 1);
        cyc(4'b0100);
        chk("seq_rise_state", F_STATE, 1);
        cyc(4'b0000);
        chk("seq_trig_state", F_STATE, 2); chk("seq_trig_addr", F_TRIG, 7);
        cyc(4'b0000);
        chk("seq_done", F_STATE, 3); chk("seq_stop", F_STOP, 8); chk("seq_vcnt", F_VCNT, 9);

        // store mask: sig3 high only, post_count 0 acts as 1; config changed after start
        bus.store_always   = 1'b0;
        bus.store_mask_vec = 12'h200;
        bus.trig_mask_vec  = {12'h003, 12'h000};
        bus.trig_count_vec = {8'd1, 8'd1};
        bus.post_count     = 5'd0;
        bus.signals_in     = 4'h0;
        do_start();
        bus.store_always  = 1'b1;
        bus.trig_mask_vec = '0;
        bus.post_count    = 5'd5;
        for (int c = 1; c <= 5; c++) cyc((c % 2 == 1) ? 4'b1000 : 4'b0000);
        chk("mask_armed", F_STATE, 1); chk("mask_pre_vcnt", F_VCNT, 3);
        cyc(4'b0001);
        chk("mask_done", F_STATE, 3); chk("mask_vcnt", F_VCNT, 4);
        chk("mask_trig", F_TRIG, 3);  chk("mask_stop", F_STOP, 3);
        cyc(4'b1000);
        chk("mask_hold_vcnt", F_VCNT, 4);
        bus.read_req_first = 1'b1; rd_q.push_back(8); tick(); bus.read_req_first = 1'b0;
        bus.read_req_next = 1'b1;
        rd_q.push_back(8); tick();
        rd_q.push_back(8); tick();
        rd_q.push_back(1); tick();
        bus.read_req_next = 1'b0;
        tick();

        // abort in POST, then start+abort together, then restart
        cfg_basic(8);
        bus.signals_in = 4'h0;
        do_start();
        cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h1);
        chk("abort_pre_post", F_STATE, 2); chk("abort_pre_trig", F_TRIG, 3);
        bus.abort = 1'b1; cyc(4'h1); bus.abort = 1'b0;
        chk("abort_state", F_STATE, 0); chk("abort_vcnt", F_VCNT, 0);
        chk("abort_trig_kept", F_TRIG, 3); chk("abort_stop_kept", F_STOP, 3);
        do_start();
        cyc(4'h0);
        bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
        chk("startabort_state", F_STATE, 0); chk("startabort_vcnt", F_VCNT, 0);
        do_start();
        chk("restart_state", F_STATE, 1); chk("restart_vcnt", F_VCNT, 0);
        cyc(4'h0);
        chk("restart_stop", F_STOP, 0); chk("restart_vcnt1", F_VCNT, 1);

        // async reset mid-capture
        do_start();
        cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h1);
        chk("ar_pre_post", F_STATE, 2);
        @(posedge src_clk); #3;
        src_reset = 1'b1;
        #1;
        chk("ar_state", F_STATE, 0); chk("ar_stage", F_STAGE, 0);
        chk("ar_start", F_START, 0); chk("ar_trig", F_TRIG, 0);
        chk("ar_stop", F_STOP, 0);   chk("ar_vcnt", F_VCNT, 0);
        chk("ar_rdata", F_RDATA, 0);
        tick();
        src_reset = 1'b0;
        cyc(4'h1); cyc(4'hF); cyc(4'h0); cyc(4'h1);
        chk("ar_idle_state", F_STATE, 0); chk("ar_idle_vcnt", F_VCNT, 0);
        chk("ar_idle_stop", F_STOP, 0);
        do_start();
        cyc(4'h0);
        chk("ar_new_state", F_STATE, 1); chk("ar_new_vcnt", F_VCNT, 1);

        flush = 1'b1;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
